// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: registered 8-requester round-robin arbiter.
//
// Grants one requester at a time and holds the grant until the holder
// asserts done, drops its request, or exceeds TIMEOUT_CYC held cycles.
// Every release is followed by a one-cycle idle gap. The grant vector is
// always one-hot or all-zero, so it can feed an 8-to-3 one-hot encoder.
//
// Build option:
//   ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                      undefined -> round-robin starting after the last holder
//
// Parameters:
//   TIMEOUT_CYC  max cycles a grant may be held (0..255, 0 disables timeout)
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   req      in   8  request vector, bit k = requester k
//   done     in   1  current holder finished, release grant
//   gnt      out  8  registered one-hot grant, 8'h00 when idle
//   gnt_vld  out  1  high whenever gnt is non-zero
//   timeout  out  1  one-cycle pulse on a forced (timeout) release

module rr_arbiter_8 #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic       gnt_vld,
    output logic       timeout
);

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 8;

    localparam bit               TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             r_state;
    logic [N_REQ-1:0]   r_gnt;
    logic               r_gnt_vld;
    logic               r_timeout;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_win;
    logic [CNT_W-1:0]   r_cnt;

    state_t             w_state_nxt;
    logic [N_REQ-1:0]   w_gnt_nxt;
    logic               w_gnt_vld_nxt;
    logic               w_timeout_nxt;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [IDX_W-1:0]   w_win_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic               w_expire;
    logic               w_release;

    // First set request bit searching upward from r_ptr, wrapping 7 -> 0.
    always_comb begin
        logic [IDX_W-1:0] v_idx;
        w_found = 1'b0;
        w_pick  = '0;
        v_idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            v_idx = r_ptr + IDX_W'(k);
            if (!w_found && req[v_idx]) begin
                w_found = 1'b1;
                w_pick  = v_idx;
            end
        end
    end

    // Release terms for the current holder; only meaningful in ST_GRANT.
    always_comb begin
        w_expire  = TO_EN && (r_cnt == TO_LAST);
        w_release = done || !req[r_win] || w_expire;
    end

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_gnt_vld <= 1'b0;
            r_timeout <= 1'b0;
            r_ptr     <= '0;
            r_win     <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_vld <= w_gnt_vld_nxt;
            r_timeout <= w_timeout_nxt;
            r_ptr     <= w_ptr_nxt;
            r_win     <= w_win_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_vld_nxt = r_gnt_vld;
        w_timeout_nxt = 1'b0;
        w_ptr_nxt     = r_ptr;
        w_win_nxt     = r_win;
        w_cnt_nxt     = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt   = ST_GRANT;
                    w_gnt_nxt     = N_REQ'(1) << w_pick;
                    w_gnt_vld_nxt = 1'b1;
                    w_win_nxt     = w_pick;
                    w_cnt_nxt     = '0;
                end else begin
                    w_gnt_nxt     = '0;
                    w_gnt_vld_nxt = 1'b0;
                end
            end

            ST_GRANT: begin
                if (w_release) begin
                    w_state_nxt   = ST_IDLE;
                    w_gnt_nxt     = '0;
                    w_gnt_vld_nxt = 1'b0;
                    // A coincident done or request drop wins over the timeout.
                    w_timeout_nxt = w_expire && !done && req[r_win];
`ifdef ARB_FIXED_PRIO_EN
                    w_ptr_nxt     = '0;
`else
                    w_ptr_nxt     = r_win + IDX_W'(1);
`endif
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt     = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_gnt_nxt     = '0;
                w_gnt_vld_nxt = 1'b0;
            end
        endcase
    end

    assign gnt     = r_gnt;
    assign gnt_vld = r_gnt_vld;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.

module tb_rr_arbiter_8;

    localparam int unsigned TO_CYC = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       gnt_vld;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state.
    bit         m_busy;
    int         m_holder;
    int         m_age;
    int         m_ptr;
    logic [7:0] m_gnt;
    logic       m_to;

    rr_arbiter_8 #(.TIMEOUT_CYC(TO_CYC)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Grant must never be multi-hot.
    always @(negedge clk) begin
        check("onehot", 8'($countones(gnt) <= 1), 8'd1);
    end

    function automatic void model_reset();
        m_busy   = 1'b0;
        m_holder = 0;
        m_age    = 0;
        m_ptr    = 0;
        m_gnt    = 8'h00;
        m_to     = 1'b0;
    endfunction

    // One clock edge of the arbiter's rules, applied to the current inputs.
    function automatic void model_step(input logic [7:0] r, input logic d);
        bit expired;
        bit dropped;
        m_to = 1'b0;
        if (!m_busy) begin
            m_gnt = 8'h00;
            for (int k = 0; k < 8; k++) begin
                int idx;
                idx = (m_ptr + k) % 8;
                if (!m_busy && r[idx]) begin
                    m_busy   = 1'b1;
                    m_holder = idx;
                    m_age    = 0;
                    m_gnt    = 8'(1 << idx);
                end
            end
        end else begin
            dropped = (r[m_holder] == 1'b0);
            expired = (TO_CYC != 0) && (m_age == int'(TO_CYC) - 1);
            if (d || dropped || expired) begin
                m_busy = 1'b0;
                m_gnt  = 8'h00;
                m_to   = expired && !d && !dropped;
`ifdef ARB_FIXED_PRIO_EN
                m_ptr  = 0;
`else
                m_ptr  = (m_holder + 1) % 8;
`endif
            end else if (m_age < 255) begin
                m_age++;
            end
        end
    endfunction

    task automatic drive(input logic [7:0] r, input logic d);
        req  = r;
        done = d;
    endtask

    // Advance one edge, update the model, compare just after the edge.
    task automatic cycle();
        @(posedge clk);
        model_step(req, done);
        #1;
        check("gnt", gnt, m_gnt);
        check("gnt_vld", 8'(gnt_vld), 8'(m_gnt != 8'h00));
        check("timeout", 8'(timeout), 8'(m_to));
    endtask

    initial begin
        logic [7:0] exp_g;
        rst_n = 1'b0;
        drive(8'h00, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", gnt, 8'h00);
        check("rst_vld", 8'(gnt_vld), 8'h00);
        check("rst_to", 8'(timeout), 8'h00);
        rst_n = 1'b1;

        // Basic: bit0 wins, then ptr=1 skips bit0 (fixed build re-grants bit0).
        drive(8'h05, 1'b0); cycle();
        check("basic_g0", gnt, 8'h01);
        drive(8'h05, 1'b1); cycle();
        check("basic_gap", gnt, 8'h00);
        drive(8'h05, 1'b0); cycle();
`ifdef ARB_FIXED_PRIO_EN
        check("basic_g1", gnt, 8'h01);
`else
        check("basic_g1", gnt, 8'h04);
`endif
        drive(8'h00, 1'b0); cycle();

        // Wrap-around through bit7.
        drive(8'h80, 1'b0); cycle();
        check("wrap_g7", gnt, 8'h80);
        drive(8'h80, 1'b1); cycle();
        drive(8'h81, 1'b0); cycle();
        check("wrap_g0", gnt, 8'h01);
        drive(8'h81, 1'b1); cycle();
        drive(8'h81, 1'b0); cycle();
`ifdef ARB_FIXED_PRIO_EN
        check("wrap_ptr1", gnt, 8'h01);
`else
        check("wrap_ptr1", gnt, 8'h80);
`endif
        drive(8'h00, 1'b0); cycle();

        // Timeout: 4 held cycles, forced release with pulse, regrant.
        drive(8'h08, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("to_hold", gnt, 8'h08);
        end
        cycle();
        check("to_rel", gnt, 8'h00);
        check("to_pulse", 8'(timeout), 8'h01);
        cycle();
        check("to_regrant", gnt, 8'h08);
        check("to_clr", 8'(timeout), 8'h00);
        repeat (3) cycle();
        drive(8'h08, 1'b1); cycle();
        check("to_done_rel", gnt, 8'h00);
        check("to_done_nopulse", 8'(timeout), 8'h00);
        drive(8'h00, 1'b0); cycle();

        // Request drop and done while idle.
        drive(8'h02, 1'b0); cycle();
        check("drop_g", gnt, 8'h02);
        drive(8'h00, 1'b0); cycle();
        check("drop_rel", gnt, 8'h00);
        check("drop_noto", 8'(timeout), 8'h00);
        drive(8'h00, 1'b1); cycle(); cycle();
        check("idle_done", gnt, 8'h00);

        // Async reset mid-grant.
        drive(8'h10, 1'b0); cycle();
        check("ar_g", gnt, 8'h10);
        #2 rst_n = 1'b0;
        #1 check("ar_clear", gnt, 8'h00);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'hFF, 1'b0); cycle();
        check("ar_restart", gnt, 8'h01);
        drive(8'hFF, 1'b1); cycle();

        // All requesting, done after each grant.
        for (int i = 1; i <= 9; i++) begin
            drive(8'hFF, 1'b0); cycle();
`ifdef ARB_FIXED_PRIO_EN
            exp_g = 8'h01;
`else
            exp_g = 8'(1 << (i % 8));
`endif
            check("ff_seq", gnt, exp_g);
            drive(8'hFF, 1'b1); cycle();
        end

        // Randomized traffic.
        drive(8'h00, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] r;
            r = req;
            if ($urandom_range(0, 3) == 0) begin
                r = 8'($urandom);
                if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
            end
            drive(r, $urandom_range(0, 7) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
